// File: rtl/inst_prefetch_buf_if.sv
// Fetch-side bundle of inst_prefetch_buf: instruction memory read port, CPU handshake, redirect.
// master = prefetch buffer, slave = memory/CPU environment.
interface inst_prefetch_buf_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned CW = 3
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_take;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] q_count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, q_count,
        input  imem_rdata, inst_take, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, q_count,
        output imem_rdata, inst_take, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue: sequential word fetch ahead of the CPU, PC-tagged FIFO, redirect flush.
// Optional PREFETCH_STATS_EN adds flush_drop_cnt and stall_cnt saturating counters.
module inst_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned AW       = 11
) (
    input  logic                clock,
    input  logic                reset,
    inst_prefetch_buf_if.master bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]         flush_drop_cnt,
    output logic [15:0]         stall_cnt
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   inflight_pc_q;
    logic          inflight_q;
    logic          run_q;

    logic [CW-1:0] occ;
    logic          issue, do_wr, do_rd;

    // Occupancy reserves a slot for the in-flight word so a response always has room.
    always_comb begin
        occ   = count_q + CW'(inflight_q);
        issue = run_q && !bus.redirect && (occ < DepthC);
        do_wr = inflight_q && !bus.redirect;
        do_rd = bus.inst_take && (count_q != '0) && !bus.redirect;
    end

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_pc_q[AW+1:2];
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = mem_inst[rd_ptr_q];
    assign bus.inst_pc    = mem_pc[rd_ptr_q];
    assign bus.q_count    = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            run_q         <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            run_q <= 1'b1;
            if (bus.redirect) begin
                // Clearing inflight kills the pending response; it is never written.
                fetch_pc_q <= bus.redirect_pc & ~32'h3;
                inflight_q <= 1'b0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    inflight_pc_q <= fetch_pc_q;
                    fetch_pc_q    <= fetch_pc_q + 32'd4;
                end
                if (do_wr) begin
                    mem_inst[wr_ptr_q] <= bus.imem_rdata;
                    mem_pc[wr_ptr_q]   <= inflight_pc_q;
                    wr_ptr_q           <= wr_ptr_q + 1'b1;
                end
                if (do_rd) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                unique case ({do_wr, do_rd})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, flush_drop_cnt} + 17'(occ);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_drop_cnt <= '0;
            stall_cnt      <= '0;
        end else begin
            if (bus.redirect) begin
                flush_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (!bus.redirect && (count_q == '0) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed self-checking bench for inst_prefetch_buf (DEPTH=4, RESET_PC=0, AW=11).
// Memory model returns word n at word address n and holds rdata when not read.
module tb_inst_prefetch_buf;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    inst_prefetch_buf_if #(.AW(11), .CW(3)) bus ();

`ifdef PREFETCH_STATS_EN
    logic [15:0] flush_drop_cnt;
    logic [15:0] stall_cnt;
`endif

    inst_prefetch_buf #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .AW       (11)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus.master)
`ifdef PREFETCH_STATS_EN
        ,
        .flush_drop_cnt (flush_drop_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.imem_req) bus.imem_rdata <= {21'b0, bus.imem_addr};
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        bus.inst_take   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.imem_rdata = 32'h0;
        do_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.q_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_ctrl got req=%b valid=%b cnt=%0d exp 0/0/0",
                     bus.imem_req, bus.inst_valid, bus.q_count);
        end
        checks++;
        if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got inst=%h pc=%h exp 0/0", bus.inst, bus.inst_pc);
        end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        int exp_req [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
        int exp_cnt [8] = '{0, 0, 0, 1, 2, 3, 4, 4};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            #1;
            checks++;
            if (bus.imem_req !== exp_req[c][0] || bus.q_count !== exp_cnt[c][2:0]) begin
                failures++;
                $display("FAIL fill_c%0d got req=%b cnt=%0d exp req=%0d cnt=%0d",
                         c, bus.imem_req, bus.q_count, exp_req[c], exp_cnt[c]);
            end
            if (exp_req[c] == 1) begin
                checks++;
                if (bus.imem_addr !== 11'(c - 1)) begin
                    failures++;
                    $display("FAIL fill_addr_c%0d got %0d exp %0d", c, bus.imem_addr, c - 1);
                end
            end
        end
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL fill_head got valid=%b inst=%h pc=%h exp 1/0/0",
                     bus.inst_valid, bus.inst, bus.inst_pc);
        end
`ifdef PREFETCH_STATS_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stall_cnt got %0d exp 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        bus.inst_take = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) step();
            #1;
            checks++;
            if (c < 3) begin
                if (bus.inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_empty_c%0d got valid=%b exp 0", c, bus.inst_valid);
                end
            end else if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * (c - 3)) ||
                         bus.inst !== 32'(c - 3) || bus.q_count !== 3'd1) begin
                failures++;
                $display("FAIL stream_c%0d got valid=%b pc=%h inst=%h cnt=%0d exp 1/%h/%h/1",
                         c, bus.inst_valid, bus.inst_pc, bus.inst, bus.q_count,
                         4 * (c - 3), c - 3);
            end
        end
        bus.inst_take = 1'b0;
    endtask

    task automatic test_redirect_full();
        do_reset();
        repeat (7) step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        #1;
        checks++;
        if (bus.q_count !== 3'd4 || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL redir_cycle got cnt=%0d req=%b exp 4/0", bus.q_count, bus.imem_req);
        end
        step();
        bus.redirect = 1'b0;
        #1;
        checks++;
        if (bus.q_count !== 3'd0 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== 11'd64) begin
            failures++;
            $display("FAIL redir_next got cnt=%0d valid=%b req=%b addr=%0d exp 0/0/1/64",
                     bus.q_count, bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        step();
        step();
        #1;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== 32'd64) begin
            failures++;
            $display("FAIL redir_first got valid=%b pc=%h inst=%h exp 1/100/40",
                     bus.inst_valid, bus.inst_pc, bus.inst);
        end
`ifdef PREFETCH_STATS_EN
        checks++;
        if (flush_drop_cnt !== 16'd4) begin
            failures++;
            $display("FAIL redir_drop got %0d exp 4", flush_drop_cnt);
        end
`endif
    endtask

    task automatic test_redirect_kill();
        do_reset();
        repeat (4) step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        #1;
        step();
        bus.redirect = 1'b0;
        #1;
        checks++;
        if (bus.q_count !== 3'd0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h80) begin
            failures++;
            $display("FAIL kill_next got cnt=%0d req=%b addr=%h exp 0/1/80",
                     bus.q_count, bus.imem_req, bus.imem_addr);
        end
        step();
        #1;
        checks++;
        if (bus.q_count !== 3'd0 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_noenq got cnt=%0d valid=%b exp 0/0", bus.q_count, bus.inst_valid);
        end
        step();
        #1;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h200 || bus.inst !== 32'h80 ||
            bus.q_count !== 3'd1) begin
            failures++;
            $display("FAIL kill_first got valid=%b pc=%h inst=%h cnt=%0d exp 1/200/80/1",
                     bus.inst_valid, bus.inst_pc, bus.inst, bus.q_count);
        end
`ifdef PREFETCH_STATS_EN
        checks++;
        if (flush_drop_cnt !== 16'd3) begin
            failures++;
            $display("FAIL kill_drop got %0d exp 3", flush_drop_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) step();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.q_count !== 3'd0 ||
            bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_zero got req=%b valid=%b cnt=%0d inst=%h pc=%h exp all 0",
                     bus.imem_req, bus.inst_valid, bus.q_count, bus.inst, bus.inst_pc);
        end
        #1;
        reset = 1'b1;
        for (int c = 1; c < 4; c++) begin
            step();
            #1;
            checks++;
            if (c == 1 && (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'd0 ||
                           bus.q_count !== 3'd0)) begin
                failures++;
                $display("FAIL rstmid_restart got req=%b addr=%0d cnt=%0d exp 1/0/0",
                         bus.imem_req, bus.imem_addr, bus.q_count);
            end else if (c == 2 && bus.q_count !== 3'd0) begin
                failures++;
                $display("FAIL rstmid_stale got cnt=%0d exp 0", bus.q_count);
            end else if (c == 3 && (bus.q_count !== 3'd1 || bus.inst !== 32'h0 ||
                                    bus.inst_pc !== 32'h0)) begin
                failures++;
                $display("FAIL rstmid_first got cnt=%0d inst=%h pc=%h exp 1/0/0",
                         bus.q_count, bus.inst, bus.inst_pc);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc   [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        logic [31:0] exp_inst [4] = '{32'h7FE, 32'h7FF, 32'h0, 32'h1};
        do_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        step();
        bus.redirect = 1'b0;
        repeat (6) step();
        #1;
        checks++;
        if (bus.q_count !== 3'd4 || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL wrap_full got cnt=%0d req=%b exp 4/0", bus.q_count, bus.imem_req);
        end
        bus.inst_take = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                step();
                #1;
            end
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc[k] ||
                bus.inst !== exp_inst[k]) begin
                failures++;
                $display("FAIL wrap_%0d got valid=%b pc=%h inst=%h exp 1/%h/%h",
                         k, bus.inst_valid, bus.inst_pc, bus.inst, exp_pc[k], exp_inst[k]);
            end
        end
        bus.inst_take = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_redirect_full();
        test_redirect_kill();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
